// File: rtl/video_pkg.sv
// Shared timing defaults, fetch slot numbers and arbiter state encoding for the
// character-cell VRAM fetch path.
package video_pkg;

   localparam int H_DISPLAY_DEF = 256;
   localparam int H_TOTAL_DEF   = 309;
   localparam int V_DISPLAY_DEF = 240;

   localparam logic [15:0] NAME_BASE = 16'h7C00;
   localparam logic [15:0] FONT_BASE = 16'h7000;
   localparam logic [15:0] ATTR_BASE = 16'h7800;

   localparam logic [2:0] SLOT_NAME       = 3'd0;
   localparam logic [2:0] SLOT_TILE       = 3'd1;
   localparam logic [2:0] SLOT_FONT       = 3'd2;
   localparam logic [2:0] SLOT_LATCH      = 3'd3;
   localparam logic [2:0] SLOT_ATTR       = 3'd4;
   localparam logic [2:0] SLOT_ATTR_LATCH = 3'd5;
   localparam logic [2:0] SLOT_LOAD       = 3'd7;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_WAIT = 2'd1,
      ARB_ACK  = 2'd2
   } arb_state_t;

   // Slot 4 is only reserved when the attribute fetch is built in.
   function automatic logic is_cpu_slot(input logic [2:0] slot, input logic window,
                                        input logic attr_en);
      if (!window) return 1'b1;
      if (attr_en && slot == SLOT_ATTR) return 1'b0;
      return slot >= SLOT_LATCH;
   endfunction

endpackage

// File: rtl/cell_slot_timer.sv
// Cell slot counter, fetch column counter and fetch-window flag, aligned so that
// slot 0 of the first cell fetch lands on hpos == H_TOTAL-8.
module cell_slot_timer
   import video_pkg::*;
#(
   parameter int H_DISPLAY = H_DISPLAY_DEF,
   parameter int H_TOTAL   = H_TOTAL_DEF,
   parameter int V_DISPLAY = V_DISPLAY_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [8:0] i_hpos,
   input  logic [8:0] i_vpos,
   output logic [2:0] o_slot,
   output logic [4:0] o_col,
   output logic       o_fetch_window
);

   localparam logic [8:0] HPOS_SYNC    = 9'(H_TOTAL - 8);
   localparam logic [8:0] HPOS_WIN_END = 9'(H_DISPLAY - 8);
   localparam logic [8:0] VPOS_END     = 9'(V_DISPLAY);

   logic [2:0] r_slot;
   logic [4:0] r_col;
   logic       w_sync;

   // The force applies in the sync cycle itself so slot tracks hpos[2:0] on screen.
   assign w_sync         = (i_hpos == HPOS_SYNC);
   assign o_slot         = w_sync ? 3'd0 : r_slot;
   assign o_col          = w_sync ? 5'd0 : r_col;
   assign o_fetch_window = (i_vpos < VPOS_END) &&
                           ((i_hpos >= HPOS_SYNC) || (i_hpos < HPOS_WIN_END));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_slot <= 3'd0;
         r_col  <= 5'd0;
      end else begin
         r_slot <= o_slot + 3'd1;
         r_col  <= (o_slot == 3'd7) ? o_col + 5'd1 : o_col;
      end
   end

endmodule

// File: rtl/vram_fetch_arbiter.sv
// Shares one synchronous VRAM port between the character-cell fetch and a CPU.
// Build option VRAM_COLOR_ATTR_EN adds a per-cell foreground colour fetch in slot 4.
//
// state    | meaning
// ARB_IDLE | no CPU access in flight; grant on cpu_req in a CPU slot
// ARB_WAIT | RAM returning read data for the granted access
// ARB_ACK  | cpu_ack pulse, cpu_rdata valid
module vram_fetch_arbiter
   import video_pkg::*;
#(
   parameter int H_DISPLAY = H_DISPLAY_DEF,
   parameter int H_TOTAL   = H_TOTAL_DEF,
   parameter int V_DISPLAY = V_DISPLAY_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [8:0]  hpos,
   input  logic [8:0]  vpos,
   input  logic        display_on,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_wdata,
   output logic        cpu_ack,
   output logic [7:0]  cpu_rdata,
   output logic [15:0] mem_addr,
   output logic        mem_we,
   output logic [7:0]  mem_wdata,
   input  logic [7:0]  mem_rdata,
   output logic        pixel,
   output logic [2:0]  fg_color
);

`ifdef VRAM_COLOR_ATTR_EN
   localparam logic ATTR_EN = 1'b1;
`else
   localparam logic ATTR_EN = 1'b0;
`endif

   logic [2:0]  w_slot;
   logic [4:0]  w_col;
   logic        w_window;
   logic        w_cpu_slot;
   logic [15:0] w_addr;
   logic        w_we;
   logic [7:0]  w_wdata;
   arb_state_t  r_state;
   arb_state_t  w_state_next;
   logic [7:0]  r_tile;
   logic [7:0]  r_font_pend;
   logic [7:0]  r_shifter;
   logic [7:0]  r_cpu_rdata;

   cell_slot_timer #(
      .H_DISPLAY (H_DISPLAY),
      .H_TOTAL   (H_TOTAL),
      .V_DISPLAY (V_DISPLAY)
   ) u_slot_timer (
      .clk            (clk),
      .rst_n          (reset),
      .i_hpos         (hpos),
      .i_vpos         (vpos),
      .o_slot         (w_slot),
      .o_col          (w_col),
      .o_fetch_window (w_window)
   );

   assign w_cpu_slot = is_cpu_slot(w_slot, w_window, ATTR_EN);

   always_comb begin
      w_state_next = r_state;
      w_addr       = 16'h0000;
      w_we         = 1'b0;
      w_wdata      = 8'h00;
      if (w_window && w_slot == SLOT_NAME)
         w_addr = NAME_BASE + {6'd0, vpos[7:3], w_col};
      else if (w_window && w_slot == SLOT_FONT)
         w_addr = FONT_BASE + {5'd0, r_tile, vpos[2:0]};
`ifdef VRAM_COLOR_ATTR_EN
      else if (w_window && w_slot == SLOT_ATTR)
         w_addr = ATTR_BASE + {6'd0, vpos[7:3], w_col};
`endif
      case (r_state)
         ARB_IDLE: begin
            if (cpu_req && w_cpu_slot) begin
               w_addr       = cpu_addr;
               w_we         = cpu_we;
               w_wdata      = cpu_wdata;
               w_state_next = ARB_WAIT;
            end
         end
         ARB_WAIT: w_state_next = ARB_ACK;
         ARB_ACK:  w_state_next = ARB_IDLE;
         default:  w_state_next = ARB_IDLE;
      endcase
   end

   // Port outputs are gated by reset so an in-flight write strobe drops at once.
   assign mem_addr  = reset ? w_addr : 16'h0000;
   assign mem_we    = reset & w_we;
   assign mem_wdata = reset ? w_wdata : 8'h00;
   assign cpu_ack   = (r_state == ARB_ACK);
   assign cpu_rdata = r_cpu_rdata;
   assign pixel     = r_shifter[7] & display_on;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ARB_IDLE;
         r_tile      <= 8'h00;
         r_font_pend <= 8'h00;
         r_shifter   <= 8'h00;
         r_cpu_rdata <= 8'h00;
      end else begin
         r_state <= w_state_next;
         if (r_state == ARB_WAIT) r_cpu_rdata <= mem_rdata;
         if (w_window && w_slot == SLOT_TILE) r_tile <= mem_rdata;
         if (w_window && w_slot == SLOT_LATCH) r_font_pend <= mem_rdata;
         if (w_window && w_slot == SLOT_LOAD) r_shifter <= r_font_pend;
         else r_shifter <= {r_shifter[6:0], 1'b0};
      end
   end

`ifdef VRAM_COLOR_ATTR_EN
   logic [2:0] r_attr_pend;
   logic [2:0] r_fg_color;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_attr_pend <= 3'b000;
         r_fg_color  <= 3'b111;
      end else begin
         if (w_window && w_slot == SLOT_ATTR_LATCH) r_attr_pend <= mem_rdata[2:0];
         if (w_window && w_slot == SLOT_LOAD) r_fg_color <= r_attr_pend;
      end
   end

   assign fg_color = r_fg_color;
`else
   assign fg_color = 3'b111;
`endif

endmodule

// File: tb/tb_vram_fetch_arbiter.sv
// Directed bench for vram_fetch_arbiter with a behavioural synchronous VRAM and a
// hand-stepped sync position; covers VRAM_COLOR_ATTR_EN when defined.
module tb_vram_fetch_arbiter;

   logic        clk;
   logic        reset;
   logic [8:0]  hpos;
   logic [8:0]  vpos;
   logic        display_on;
   logic        cpu_req;
   logic        cpu_we;
   logic [15:0] cpu_addr;
   logic [7:0]  cpu_wdata;
   logic        cpu_ack;
   logic [7:0]  cpu_rdata;
   logic [15:0] mem_addr;
   logic        mem_we;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata;
   logic        pixel;
   logic [2:0]  fg_color;

   logic [7:0]  vram [0:65535];
   logic        pl_we;
   logic [15:0] pl_addr;
   logic [7:0]  pl_data;

   int n_checks = 0;
   int n_errors = 0;

   vram_fetch_arbiter dut (
      .clk        (clk),
      .reset      (reset),
      .hpos       (hpos),
      .vpos       (vpos),
      .display_on (display_on),
      .cpu_req    (cpu_req),
      .cpu_we     (cpu_we),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_ack    (cpu_ack),
      .cpu_rdata  (cpu_rdata),
      .mem_addr   (mem_addr),
      .mem_we     (mem_we),
      .mem_wdata  (mem_wdata),
      .mem_rdata  (mem_rdata),
      .pixel      (pixel),
      .fg_color   (fg_color)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (mem_we) vram[mem_addr] <= mem_wdata;
      else if (pl_we) vram[pl_addr] <= pl_data;
      mem_rdata <= vram[mem_addr];
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      hpos = (hpos == 9'd308) ? 9'd0 : hpos + 9'd1;
      display_on = (hpos < 9'd256) && (vpos < 9'd240);
      @(negedge clk);
   endtask

   task automatic goto_hpos(input logic [8:0] target);
      for (int i = 0; i < 400; i++) begin
         if (hpos == target) break;
         tick();
      end
   endtask

   task automatic poke(input logic [15:0] addr, input logic [7:0] data);
      pl_addr = addr;
      pl_data = data;
      pl_we   = 1'b1;
      @(posedge clk);
      #1;
      pl_we   = 1'b0;
   endtask

   // Issues one request and reports request-to-grant and grant-to-ack delays.
   task automatic cpu_access(input logic we, input logic [15:0] addr, input logic [7:0] wd,
                             output int gd, output int ad, output logic [7:0] rd,
                             output int wecnt);
      bit granted;
      gd = 99; ad = 99; rd = 8'h00; wecnt = 0; granted = 0;
      cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
      #1;
      for (int n = 0; n < 12; n++) begin
         if (mem_we) wecnt++;
         if (!granted && mem_addr == addr) begin
            gd = n;
            granted = 1;
         end
         if (cpu_ack) begin
            ad = n - gd;
            rd = cpu_rdata;
            break;
         end
         tick();
      end
      cpu_req = 1'b0;
      #1;
   endtask

   int         gd, ad, wecnt, grants, acks, fetches;
   logic [7:0] rd;
   logic [7:0] font_row;
   int         exp_s4_gd;
   logic [2:0] exp_fg;

   initial begin
      reset = 1'b0; hpos = 9'd0; vpos = 9'd0; display_on = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0ABC; cpu_wdata = 8'hFF;
      pl_we = 1'b0; pl_addr = 16'h0000; pl_data = 8'h00;
`ifdef VRAM_COLOR_ATTR_EN
      exp_s4_gd = 1; exp_fg = 3'b100;
`else
      exp_s4_gd = 0; exp_fg = 3'b111;
`endif
      #2;
      chk("rst_ack", cpu_ack, 1'b0);
      chk("rst_we", mem_we, 1'b0);
      chk("rst_addr", mem_addr, 16'h0000);
      chk("rst_wdata", mem_wdata, 8'h00);
      chk("rst_rdata", cpu_rdata, 8'h00);
      chk("rst_pixel", pixel, 1'b0);
      chk("rst_fg", fg_color, 3'b111);
      cpu_req = 1'b0;

      poke(16'h7C00, 8'h41);
      poke(16'h7208, 8'hA5);
      poke(16'h7C01, 8'h00);
      poke(16'h7000, 8'h00);
      poke(16'h1234, 8'h5A);
      poke(16'h7800, 8'h04);

      hpos = 9'd295; vpos = 9'd0; display_on = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      // cell 0 fetch at the end of the previous line, display from hpos 0
      goto_hpos(9'd301);
      chk("name_addr", mem_addr, 16'h7C00);
      tick(); tick();
      chk("font_addr", mem_addr, 16'h7208);
      goto_hpos(9'd0);
      chk("fg_cell0", fg_color, exp_fg);
      font_row = 8'hA5;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("pixel_h%0d", i), pixel, font_row[7 - i]);
         tick();
      end
      chk("pixel_h8", pixel, 1'b0);

      // read request at slot 0 of a visible cell
      cpu_access(1'b0, 16'h1234, 8'h00, gd, ad, rd, wecnt);
      chk("rd_s0_grant", gd, 3);
      chk("rd_s0_ack", ad, 2);
      chk("rd_s0_data", rd, 8'h5A);
      chk("rd_s0_we", wecnt, 0);

      goto_hpos(9'd20);
      cpu_access(1'b0, 16'h1234, 8'h00, gd, ad, rd, wecnt);
      chk("rd_s4_grant", gd, exp_s4_gd);
      chk("rd_s4_ack", ad, 2);
      chk("rd_s4_data", rd, 8'h5A);

      // vblank write then readback
      vpos = 9'd250;
      tick(); tick();
      cpu_access(1'b1, 16'h0100, 8'hC3, gd, ad, rd, wecnt);
      chk("wr_vb_grant", gd, 0);
      chk("wr_vb_ack", ad, 2);
      chk("wr_vb_we", wecnt, 1);
      tick();
      cpu_access(1'b0, 16'h0100, 8'h00, gd, ad, rd, wecnt);
      chk("rb_vb_grant", gd, 0);
      chk("rb_vb_data", rd, 8'hC3);
      chk("rb_vb_we", wecnt, 0);

      // continuously held request in vblank
      tick();
      grants = 0; acks = 0; fetches = 0;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0200;
      #1;
      for (int n = 0; n < 12; n++) begin
         if (mem_addr == 16'h0200) grants++;
         if (cpu_ack) acks++;
         if (mem_addr[15:12] == 4'h7) fetches++;
         tick();
      end
      cpu_req = 1'b0;
      tick(); tick(); tick();
      chk("b2b_grants", grants, 4);
      chk("b2b_acks", acks, 4);
      chk("b2b_fetch", fetches, 0);

      // reset during the WAIT cycle
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0300;
      #1;
      chk("rw_grant", mem_addr, 16'h0300);
      tick();
      reset = 1'b0;
      #1;
      chk("rw_ack", cpu_ack, 1'b0);
      chk("rw_we", mem_we, 1'b0);
      chk("rw_addr", mem_addr, 16'h0000);
      chk("rw_wdata", mem_wdata, 8'h00);
      chk("rw_rdata", cpu_rdata, 8'h00);
      chk("rw_pixel", pixel, 1'b0);
      chk("rw_fg", fg_color, 3'b111);
      acks = 0;
      for (int n = 0; n < 3; n++) begin
         tick();
         if (cpu_ack) acks++;
      end
      chk("rw_no_ack", acks, 0);
      cpu_req = 1'b0;
      reset = 1'b1;
      tick();
      cpu_access(1'b0, 16'h1234, 8'h00, gd, ad, rd, wecnt);
      chk("resume_grant", gd, 0);
      chk("resume_ack", ad, 2);
      chk("resume_data", rd, 8'h5A);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/vram_fetch_arbiter.md
Name: vram_fetch_arbiter

Overview:
- Time-slot scheduler that shares one synchronous video RAM port between the character-cell display fetch and a CPU requester.
- Driven by the hvsync generator's hpos/vpos/display_on.
- Each 8-pixel cell uses fixed slots to fetch the tile index and font byte for the next cell, then serialises that byte as the pixel output; the remaining slots, and all slots outside the fetch window, go to the CPU through a req/ack handshake.

Parameters:
- H_DISPLAY, 256, visible pixels per line (multiple of 8)
- H_TOTAL, 309, total clocks per line (hpos wraps H_TOTAL-1 -> 0)
- V_DISPLAY, 240, visible lines
- NAME_BASE, 16'h7C00, nametable base address (32 cols x 32 rows)
- FONT_BASE, 16'h7000, font base address (8 bytes per tile)
- ATTR_BASE, 16'h7800, attribute table base (used only with the option)

Ports:
- clk  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- hpos  in  9  horizontal position from the sync generator
- vpos  in  9  vertical position from the sync generator
- display_on  in  1  visible-area flag
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read; stable while cpu_req
- cpu_addr  in  16  CPU address; stable while cpu_req
- cpu_wdata  in  8  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  8  read data; valid while cpu_ack=1
- mem_addr  out  16  RAM address
- mem_we  out  1  RAM write strobe
- mem_wdata  out  8  RAM write data
- mem_rdata  in  8  RAM read data; valid the cycle after its address
- pixel  out  1  font pixel, gated by display_on
- fg_color  out  3  foreground colour (BGR)

Behaviour:
- Reset values: all outputs 0, except fg_color = 3'b111. Slot counter = 0, column = 0, arbiter state = IDLE.
- Slot counter s[2:0]:
  - forced to 0 when hpos == H_TOTAL-8; otherwise increments each clk and wraps 7 -> 0.
  - Because H_DISPLAY is a multiple of 8, s == hpos[2:0] throughout the visible area.
- Column counter col[4:0]:
  - set to 0 at hpos == H_TOTAL-8; increments when s == 7.
  - Always holds the cell being fetched, which is the next displayed cell.
- Fetch window: vpos < V_DISPLAY AND (hpos >= H_TOTAL-8 OR hpos < H_DISPLAY-8).
- Fetch slots, applied only inside the window:
  - s=0: mem_addr = NAME_BASE + {vpos[7:3], col}.
  - s=1: tile <= mem_rdata; port idle.
  - s=2: mem_addr = FONT_BASE + {tile, vpos[2:0]}.
  - s=3: font_pend <= mem_rdata.
  - s=7: shifter <= font_pend. Each other clk the shifter shifts left.
  - pixel = shifter[7] & display_on.
- CPU slots: s in {3,4,5,6,7} inside the window; every clk outside it.
- Arbiter FSM:
  - IDLE: if cpu_req and CPU slot, grant this cycle (mem_addr = cpu_addr, mem_we = cpu_we, mem_wdata = cpu_wdata) -> WAIT.
  - WAIT: cpu_rdata <= mem_rdata -> ACK.
  - ACK: cpu_ack = 1 -> IDLE.
  - cpu_req is ignored in WAIT/ACK; the earliest next grant is the cycle after ACK.
- Ack latency is grant+2. Worst-case request-to-grant latency is 3 clocks (request arriving at s=0).
- mem_we is high only in a grant cycle. Fetch never writes.
- A fetch slot always wins over the CPU. Fetch slots have no stall path.
- cpu_req dropping before grant has no effect. Dropping after grant still completes the access.
- vpos >= V_DISPLAY: no fetch, all slots go to the CPU, shifter still shifts (pixel gated anyway).
- Reset asserted mid-access: the access is aborted, no ack is issued, and mem_we falls immediately (asynchronously).

Optional Feature:
- Macro: VRAM_COLOR_ATTR_EN.
- Defined:
  - s=4: mem_addr = ATTR_BASE + {vpos[7:3], col}.
  - s=5: attr_pend <= mem_rdata[2:0].
  - s=7: fg_color <= attr_pend.
  - CPU slots inside the window become {3,5,6,7}; worst-case request-to-grant latency stays 3.
- Undefined: fg_color is constant 3'b111; no attribute fetch.

Decomposition:
- Package video_pkg: H_DISPLAY/H_TOTAL/V_DISPLAY defaults, slot-number constants (SLOT_NAME, SLOT_TILE, SLOT_FONT, SLOT_LATCH, SLOT_ATTR, SLOT_LOAD), arbiter state enum.
- One sub-module, cell_slot_timer: slot counter, column counter, fetch_window flag.

Test Plan:
- Nametable[0] = 8'h41, font[8'h41*8 + 0] = 8'hA5, vpos=0 -> pixel over hpos 0..7 = 1,0,1,0,0,1,0,1.
- CPU read of 16'h1234 (holds 8'h5A), request at s=0 in visible line -> grant at s=3, cpu_ack at s=5, cpu_rdata = 8'h5A; no mem_we.
- CPU write 8'hC3 to 16'h0100 during vblank (vpos=250) -> grant same cycle, mem_we for exactly 1 clk, cpu_ack 2 clks later; readback returns 8'hC3.
- Back-to-back requests held continuously during vblank -> grants every 3rd clk; mem_addr never shows NAME_BASE/FONT_BASE accesses.
- Reset low in the WAIT cycle -> no cpu_ack, all outputs 0, fg_color = 3'b111; resumes correctly after release.
- With VRAM_COLOR_ATTR_EN, attribute = 8'h04 for cell 0 -> fg_color = 3'b100 from hpos 0; a CPU request at s=4 is granted at s=5.
